// File: rtl/aes_pkg.sv
// Shared AES-128 types and helpers for the round controller, key schedule and
// MixColumns datapath.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } ctrl_state_t;

  localparam int         AES128_ROUNDS = 10;
  localparam logic [7:0] RCON_INIT     = 8'h01;

  // Multiply by x in GF(2^8) modulo the AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// Round-constant register for the AES key schedule; reload wins over advance.
module aes_rcon_gen
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       reload,
  input  logic       advance,
  output logic [7:0] rcon
);

  logic [7:0] rcon_q;
  logic [7:0] rcon_d;

  always_comb begin
    rcon_d = rcon_q;
    if (reload) begin
      rcon_d = RCON_INIT;
    end else if (advance) begin
      rcon_d = xtime(rcon_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rcon_q <= RCON_INIT;
    end else begin
      rcon_q <= rcon_d;
    end
  end

  assign rcon = rcon_q;

endmodule

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: start on falling load, one init strobe, NUM_ROUNDS
// round strobes of CYCLES_PER_ROUND cycles each, then hold done until load rises.
//
// state | meaning
// IDLE  | waiting for falling edge of load; counters held at reload values
// INIT  | init_en: datapath loads plaintext^key and the cipher key
// ROUND | stepping sub-cycles; round_en on the last sub-cycle of each round
// DONE  | ciphertext valid; datapath frozen until load is sampled high
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS       = AES128_ROUNDS,
  parameter int CYCLES_PER_ROUND = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  output logic       init_en,
  output logic       round_en,
  output logic [2:0] sub_cnt,
  output logic [3:0] round,
  output logic [7:0] rcon,
  output logic       last_round,
  output logic       busy,
  output logic       done
);

  if (NUM_ROUNDS < 1 || NUM_ROUNDS > 15) begin : g_bad_num_rounds
    $error("aes_round_ctrl: NUM_ROUNDS must be 1..15");
  end
  if (CYCLES_PER_ROUND < 1 || CYCLES_PER_ROUND > 8) begin : g_bad_cycles
    $error("aes_round_ctrl: CYCLES_PER_ROUND must be 1..8");
  end

  localparam logic [2:0] SUB_LAST   = 3'(CYCLES_PER_ROUND - 1);
  localparam logic [3:0] ROUND_LAST = 4'(NUM_ROUNDS);

  ctrl_state_t state_q, state_d;
  logic        load_q, load_d;
  logic [3:0]  round_q, round_d;
  logic [2:0]  sub_cnt_q, sub_cnt_d;
  logic        rcon_reload;
  logic        rcon_advance;
  logic        start;
  logic        round_end;
  logic        final_round;

  assign start       = load_q & ~load;
  assign round_end   = (state_q == ROUND) && (sub_cnt_q == SUB_LAST);
  assign final_round = (round_q == ROUND_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      load_q    <= 1'b0;
      round_q   <= 4'd0;
      sub_cnt_q <= 3'd0;
    end else begin
      state_q   <= state_d;
      load_q    <= load_d;
      round_q   <= round_d;
      sub_cnt_q <= sub_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    load_d       = load;
    round_d      = round_q;
    sub_cnt_d    = sub_cnt_q;
    rcon_reload  = 1'b0;
    rcon_advance = 1'b0;
    unique case (state_q)
      IDLE: begin
        round_d     = 4'd0;
        sub_cnt_d   = 3'd0;
        rcon_reload = 1'b1;
        if (start) state_d = INIT;
      end
      INIT: begin
        if (load) begin
          state_d     = IDLE;
          round_d     = 4'd0;
          sub_cnt_d   = 3'd0;
          rcon_reload = 1'b1;
        end else begin
          state_d   = ROUND;
          round_d   = 4'd1;
          sub_cnt_d = 3'd0;
        end
      end
      ROUND: begin
        // A rising load aborts even on a round-end cycle; counters reload.
        if (load) begin
          state_d     = IDLE;
          round_d     = 4'd0;
          sub_cnt_d   = 3'd0;
          rcon_reload = 1'b1;
        end else if (round_end) begin
          sub_cnt_d = 3'd0;
          if (final_round) begin
            state_d = DONE;
          end else begin
            round_d      = round_q + 4'd1;
            rcon_advance = 1'b1;
          end
        end else begin
          sub_cnt_d = sub_cnt_q + 3'd1;
        end
      end
      DONE: begin
        if (load) begin
          state_d     = IDLE;
          round_d     = 4'd0;
          sub_cnt_d   = 3'd0;
          rcon_reload = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        round_d     = 4'd0;
        sub_cnt_d   = 3'd0;
        rcon_reload = 1'b1;
      end
    endcase
  end

  always_comb begin
    init_en    = (state_q == INIT);
    round_en   = round_end;
    last_round = (state_q == ROUND) && final_round;
    busy       = (state_q == INIT) || (state_q == ROUND);
    done       = (state_q == DONE);
    round      = round_q;
    sub_cnt    = sub_cnt_q;
  end

  aes_rcon_gen u_rcon_gen (
    .clk     (clk),
    .reset   (reset),
    .reload  (rcon_reload),
    .advance (rcon_advance),
    .rcon    (rcon)
  );

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Scoreboard bench for aes_round_ctrl: default instance plus a 4-cycle-round instance.
module tb_aes_round_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic       load4;

  logic       init_en, round_en, last_round, busy, done;
  logic [2:0] sub_cnt;
  logic [3:0] round;
  logic [7:0] rcon;

  logic       init_en4, round_en4, last_round4, busy4, done4;
  logic [2:0] sub_cnt4;
  logic [3:0] round4;
  logic [7:0] rcon4;

  typedef struct packed {
    logic       is_init;
    logic [3:0] rnd;
    logic [7:0] rc;
    logic       last;
  } ev_t;

  ev_t exp_q[$];
  ev_t exp4_q[$];
  int  n_vec = 0;
  int  n_err = 0;
  int  exp_sub4 = 0;

  logic [7:0] rcon_tbl [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

  always #5 clk = ~clk;

  aes_round_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .init_en    (init_en),
    .round_en   (round_en),
    .sub_cnt    (sub_cnt),
    .round      (round),
    .rcon       (rcon),
    .last_round (last_round),
    .busy       (busy),
    .done       (done)
  );

  aes_round_ctrl #(.NUM_ROUNDS(10), .CYCLES_PER_ROUND(4)) dut4 (
    .clk        (clk),
    .reset      (reset),
    .load       (load4),
    .init_en    (init_en4),
    .round_en   (round_en4),
    .sub_cnt    (sub_cnt4),
    .round      (round4),
    .rcon       (rcon4),
    .last_round (last_round4),
    .busy       (busy4),
    .done       (done4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic push_seq(input bit four, input int n_rounds);
    ev_t e;
    e.is_init = 1'b1; e.rnd = 4'd0; e.rc = 8'h01; e.last = 1'b0;
    if (four) exp4_q.push_back(e); else exp_q.push_back(e);
    for (int r = 1; r <= n_rounds; r++) begin
      e.is_init = 1'b0;
      e.rnd     = 4'(r);
      e.rc      = rcon_tbl[r-1];
      e.last    = (r == 10);
      if (four) exp4_q.push_back(e); else exp_q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Call with load just lowered while load_q is high; the next edge is the start edge.
  task automatic run_to_done(input bit four, input int lat_exp, input string name);
    int n = 0;
    tick();
    while (!(four ? done4 : done) && n < 200) begin
      tick();
      n++;
    end
    check(name, 32'(n), 32'(lat_exp));
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (init_en || round_en) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_strobe: init_en=%0b round_en=%0b round=%0d, required no strobe", init_en, round_en, round);
      end else begin
        e = exp_q.pop_front();
        check("strobe_kind", 32'(init_en), 32'(e.is_init));
        check("round", 32'(round), 32'(e.rnd));
        check("rcon", 32'(rcon), 32'(e.rc));
        check("last_round", 32'(last_round), 32'(e.last));
        if (round_en) check("sub_cnt_at_round_en", 32'(sub_cnt), 32'd0);
      end
    end
    if (last_round && !round_en) begin
      n_vec++; n_err++;
      $display("FAIL last_round_stray: last_round=1 round_en=0, required last_round only with round_en");
    end
  end

  always @(negedge clk) begin
    ev_t e;
    if (init_en4) begin
      exp_sub4 = 0;
    end else if (busy4) begin
      check("sub_cnt4_seq", 32'(sub_cnt4), 32'(exp_sub4));
      exp_sub4 = (exp_sub4 + 1) % 4;
    end
    if (init_en4 || round_en4) begin
      if (exp4_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_strobe4: init_en=%0b round_en=%0b round=%0d, required no strobe", init_en4, round_en4, round4);
      end else begin
        e = exp4_q.pop_front();
        check("strobe_kind4", 32'(init_en4), 32'(e.is_init));
        check("round4", 32'(round4), 32'(e.rnd));
        check("rcon4", 32'(rcon4), 32'(e.rc));
        check("last_round4", 32'(last_round4), 32'(e.last));
        if (round_en4) check("sub_cnt4_at_round_en", 32'(sub_cnt4), 32'd3);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    reset = 1'b1;
    load  = 1'b0;
    load4 = 1'b0;
    repeat (3) tick();
    check("rst_strobes", 32'({init_en, round_en, last_round}), 32'd0);
    check("rst_busy_done", 32'({busy, done, busy4, done4}), 32'd0);
    check("rst_round", 32'(round), 32'd0);
    check("rst_sub_cnt", 32'(sub_cnt), 32'd0);
    check("rst_rcon", 32'(rcon), 32'h01);
    reset = 1'b0;
    tick();

    // Long load, then falling edge: full encryption.
    load = 1'b1;
    repeat (20) tick();
    check("no_start_while_load_high", 32'(busy), 32'd0);
    push_seq(1'b0, 10);
    load = 1'b0;
    run_to_done(1'b0, 11, "latency_cpr1");
    check("missing_strobes_run1", 32'(exp_q.size()), 32'd0);

    // done holds with load low.
    cnt = 0;
    repeat (100) begin
      tick();
      if (!done || busy) cnt++;
    end
    check("done_held_100", 32'(cnt), 32'd0);
    load = 1'b1;
    tick();
    check("done_clear_on_load", 32'(done), 32'd0);
    check("idle_after_done", 32'(busy), 32'd0);
    repeat (3) tick();

    // Abort in round 5.
    push_seq(1'b0, 5);
    load = 1'b0;
    tick();
    repeat (5) tick();
    check("in_round5", 32'(round), 32'd5);
    load = 1'b1;
    tick();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_round", 32'(round), 32'd0);
    check("abort_rcon", 32'(rcon), 32'h01);
    repeat (5) tick();
    check("abort_strobes", 32'(exp_q.size()), 32'd0);
    push_seq(1'b0, 10);
    load = 1'b0;
    run_to_done(1'b0, 11, "latency_after_abort");
    check("missing_strobes_restart", 32'(exp_q.size()), 32'd0);

    // One-cycle load pulse while in DONE.
    load = 1'b1;
    tick();
    check("done_pulse_drop", 32'(done), 32'd0);
    push_seq(1'b0, 10);
    load = 1'b0;
    run_to_done(1'b0, 11, "latency_done_pulse");
    check("missing_strobes_pulse", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset mid-round 3.
    load = 1'b1;
    tick();
    push_seq(1'b0, 2);
    load = 1'b0;
    tick();
    repeat (3) tick();
    #2 reset = 1'b1;
    #1;
    check("async_rst_strobes", 32'({init_en, round_en, last_round}), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_round", 32'(round), 32'd0);
    check("async_rst_rcon", 32'(rcon), 32'h01);
    tick();
    reset = 1'b0;
    cnt = 0;
    repeat (20) begin
      tick();
      if (busy || done) cnt++;
    end
    check("no_start_after_reset", 32'(cnt), 32'd0);
    check("strobes_before_reset", 32'(exp_q.size()), 32'd0);

    // Column-serial rounds.
    load4 = 1'b1;
    tick();
    push_seq(1'b1, 10);
    load4 = 1'b0;
    run_to_done(1'b1, 41, "latency_cpr4");
    check("missing_strobes_cpr4", 32'(exp4_q.size()), 32'd0);
    load4 = 1'b1;
    tick();
    check("done4_clear", 32'(done4), 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
